multisim_server_apb_bridge: RTL and testbench

APB subordinate bridge for the server side of a multisim APB link: accepts APB transfers from a local manager, pushes each captured request onto a multisim request channel, waits for the matching response on a multisim response channel, then completes the APB transfer with that response. It is the counterpart of the client-side APB manager, which pulls requests from the server and pushes responses back. Channel ports are plain valid/ready handshakes; a wrapper attaches them to multisim server push/pull instances.

---
 rtl/multisim_server_apb_bridge.sv | 147 ++++++++++++++
 tb/tb_multisim_server_apb_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multisim_server_apb_bridge.sv
// multisim_server_apb_bridge
// Server-side APB subordinate bridge. Each APB transfer from the local manager
// is captured in SETUP, pushed onto the request channel, and held in ACCESS
// until the matching response arrives on the response channel. That response
// then completes the transfer with a single-cycle pready.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   i_apb_s_*          APB subordinate side (payload, psel, penable)
//   o_apb_s_*          APB response payload and pready
//   o_req_* / i_req_*  request channel (valid/ready push)
//   i_resp_* / o_resp_* response channel (valid/ready pull)
//   o_busy             transfer in flight
//   o_protocol_err     sticky APB protocol violation
//   o_txn_count        completed transfers, wraps modulo 2^32
//
// The payload type defaults only give the block standalone widths. Every real
// instance overrides them with the link's apb_req_t / apb_resp_t.
module multisim_server_apb_bridge #(
  parameter type apb_req_t  = logic [68:0],
  parameter type apb_resp_t = logic [32:0]
) (
  input  logic      clk,
  input  logic      rst,
  input  apb_req_t  i_apb_s_req,
  input  logic      i_apb_s_psel,
  input  logic      i_apb_s_penable,
  output apb_resp_t o_apb_s_resp,
  output logic      o_apb_s_pready,
  output logic      o_req_vld,
  input  logic      i_req_rdy,
  output apb_req_t  o_req_data,
  input  logic      i_resp_vld,
  output logic      o_resp_rdy,
  input  apb_resp_t i_resp_data,
  output logic      o_busy,
  output logic      o_protocol_err,
  output logic [31:0] o_txn_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  apb_req_t           req_q, req_d;
  apb_resp_t          resp_q, resp_d;
  logic               req_vld_q, req_vld_d;
  logic               resp_rdy_q, resp_rdy_d;
  logic               pready_q, pready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   txn_count_q, txn_count_d;
  logic               apb_access;

  assign apb_access = i_apb_s_psel & i_apb_s_penable;

  // Next-state, capture and output decode
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    resp_d      = resp_q;
    err_d       = err_q;
    txn_count_d = txn_count_q;

    case (state_q)
      S_IDLE: begin
        if (i_apb_s_psel && !i_apb_s_penable) begin
          req_d   = i_apb_s_req;
          state_d = S_REQ;
        end else if (apb_access) begin
          // ACCESS with no preceding SETUP: flag it, never start a channel request
          err_d = 1'b1;
        end
      end
      S_REQ: begin
        if (i_req_rdy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_resp_vld) begin
          resp_d      = i_resp_data;
          txn_count_d = txn_count_q + CNT_W'(1);
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Manager must hold ACCESS for the whole transfer; the channel side cannot
    // be retracted, so the FSM keeps running and only the flag records it.
    if (state_q != S_IDLE && !apb_access) begin
      err_d = 1'b1;
    end

    req_vld_d  = (state_d == S_REQ);
    resp_rdy_d = (state_d == S_WAIT);
    pready_d   = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= apb_req_t'(0);
      resp_q      <= apb_resp_t'(0);
      req_vld_q   <= 1'b0;
      resp_rdy_q  <= 1'b0;
      pready_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      resp_q      <= resp_d;
      req_vld_q   <= req_vld_d;
      resp_rdy_q  <= resp_rdy_d;
      pready_q    <= pready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign o_req_data     = req_q;
  assign o_apb_s_resp   = resp_q;
  assign o_req_vld      = req_vld_q;
  assign o_resp_rdy     = resp_rdy_q;
  assign o_apb_s_pready = pready_q;
  assign o_busy         = busy_q;
  assign o_protocol_err = err_q;
  assign o_txn_count    = txn_count_q;

endmodule

// File: tb/tb_multisim_server_apb_bridge.sv
// Testbench for multisim_server_apb_bridge. The expected timing of every
// transfer is derived from the channel wait counts: a transfer started in
// cycle 0 with rw request-channel stalls and sw response-channel stalls has
// o_req_vld over cycles 1..1+rw, o_resp_rdy over 2+rw..2+rw+sw and a single
// pready at 3+rw+sw.
module tb_multisim_server_apb_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } tb_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
  } tb_resp_t;

  logic        clk;
  logic        rst;
  tb_req_t     i_apb_s_req;
  logic        i_apb_s_psel;
  logic        i_apb_s_penable;
  tb_resp_t    o_apb_s_resp;
  logic        o_apb_s_pready;
  logic        o_req_vld;
  logic        i_req_rdy;
  tb_req_t     o_req_data;
  logic        i_resp_vld;
  logic        o_resp_rdy;
  tb_resp_t    i_resp_data;
  logic        o_busy;
  logic        o_protocol_err;
  logic [31:0] o_txn_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_count;
  logic        exp_err;

  multisim_server_apb_bridge #(
    .apb_req_t (tb_req_t),
    .apb_resp_t(tb_resp_t)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_apb_s_req    (i_apb_s_req),
    .i_apb_s_psel   (i_apb_s_psel),
    .i_apb_s_penable(i_apb_s_penable),
    .o_apb_s_resp   (o_apb_s_resp),
    .o_apb_s_pready (o_apb_s_pready),
    .o_req_vld      (o_req_vld),
    .i_req_rdy      (i_req_rdy),
    .o_req_data     (o_req_data),
    .i_resp_vld     (i_resp_vld),
    .o_resp_rdy     (o_resp_rdy),
    .i_resp_data    (i_resp_data),
    .o_busy         (o_busy),
    .o_protocol_err (o_protocol_err),
    .o_txn_count    (o_txn_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic tb_req_t rnd_req();
    tb_req_t r;
    r.addr  = $urandom;
    r.write = 1'($urandom);
    r.wdata = $urandom;
    r.strb  = 4'($urandom);
    return r;
  endfunction

  function automatic tb_resp_t rnd_resp();
    tb_resp_t r;
    r.rdata  = $urandom;
    r.slverr = 1'($urandom);
    return r;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    i_apb_s_psel    = 1'b0;
    i_apb_s_penable = 1'b0;
    i_req_rdy       = 1'b0;
    i_resp_vld      = 1'b0;
  endtask

  // One complete APB transfer; drop=1 releases psel in the first WAIT cycle.
  task automatic xfer(input tb_req_t rq, input tb_resp_t rs, input int rw,
                      input int sw, input bit drop);
    int         last;
    logic [3:0] exp_v;
    logic [3:0] got_v;
    last = 3 + rw + sw;

    i_apb_s_psel    = 1'b1;
    i_apb_s_penable = 1'b0;
    i_apb_s_req     = rq;
    i_req_rdy       = 1'b0;
    i_resp_vld      = 1'b0;
    i_resp_data     = rnd_resp();
    @(negedge clk);
    got_v = {o_req_vld, o_resp_rdy, o_apb_s_pready, o_busy};
    n_cmp++;
    if (got_v !== 4'b0000) begin
      n_bad++;
      $display("FAIL setup_idle: {req_vld,resp_rdy,pready,busy} got %b want 0000", got_v);
    end

    for (int c = 1; c <= last; c++) begin
      next_cycle();
      i_apb_s_psel    = 1'b1;
      i_apb_s_penable = 1'b1;
      if (drop && c == 2 + rw) i_apb_s_psel = 1'b0;
      // Payload only matters in SETUP; scramble it afterwards
      i_apb_s_req = rnd_req();
      if (c == 1 + rw)      i_req_rdy = 1'b1;
      else if (c > 1 + rw)  i_req_rdy = 1'($urandom);
      else                  i_req_rdy = 1'b0;
      if (c == 2 + rw + sw) begin
        i_resp_vld  = 1'b1;
        i_resp_data = rs;
      end else begin
        i_resp_vld  = (c < 2 + rw) ? 1'($urandom) : 1'b0;
        i_resp_data = rnd_resp();
      end
      @(negedge clk);

      exp_v = {(c <= 1 + rw), (c >= 2 + rw && c <= 2 + rw + sw), (c == last), 1'b1};
      got_v = {o_req_vld, o_resp_rdy, o_apb_s_pready, o_busy};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL handshake cycle %0d: {req_vld,resp_rdy,pready,busy} got %b want %b",
                 c, got_v, exp_v);
      end

      n_cmp++;
      if (o_req_data !== rq) begin
        n_bad++;
        $display("FAIL req_data cycle %0d: got %h want %h", c, o_req_data, rq);
      end

      n_cmp++;
      if (o_protocol_err !== exp_err) begin
        n_bad++;
        $display("FAIL protocol_err cycle %0d: got %b want %b", c, o_protocol_err, exp_err);
      end

      if (c == last) begin
        exp_count = exp_count + 32'd1;
        n_cmp++;
        if (o_apb_s_resp !== rs) begin
          n_bad++;
          $display("FAIL apb_resp: got %h want %h", o_apb_s_resp, rs);
        end
        n_cmp++;
        if (o_txn_count !== exp_count) begin
          n_bad++;
          $display("FAIL txn_count: got %h want %h", o_txn_count, exp_count);
        end
      end

      if (drop && c == 2 + rw) exp_err = 1'b1;
    end

    next_cycle();
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    i_apb_s_req = rnd_req();
    i_resp_data = rnd_resp();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({o_req_vld, o_resp_rdy, o_apb_s_pready, o_busy, o_protocol_err} !== 5'b0 ||
        o_req_data !== tb_req_t'(0) || o_apb_s_resp !== tb_resp_t'(0) ||
        o_txn_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_values: vld=%b rdy=%b pready=%b busy=%b err=%b req=%h resp=%h cnt=%h want all 0",
               o_req_vld, o_resp_rdy, o_apb_s_pready, o_busy, o_protocol_err,
               o_req_data, o_apb_s_resp, o_txn_count);
    end
    exp_count = 32'd0;
    exp_err   = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_write();
    tb_req_t  rq;
    tb_resp_t rs;
    rq.addr   = 32'hA5A5_A5A5;
    rq.write  = 1'b1;
    rq.wdata  = 32'hA5A5_A5A5;
    rq.strb   = 4'hF;
    rs.rdata  = 32'h3C3C_3C3C;
    rs.slverr = 1'b0;
    xfer(rq, rs, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    xfer(rnd_req(), rnd_resp(), 3, 5, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({o_apb_s_pready, o_busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL backpressure_single_pulse: {pready,busy} got %b want 00",
               {o_apb_s_pready, o_busy});
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) xfer(rnd_req(), rnd_resp(), 0, 0, 1'b0);
  endtask

  task automatic test_random_waits();
    for (int i = 0; i < 10; i++)
      xfer(rnd_req(), rnd_resp(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0);
  endtask

  task automatic test_protocol_errors();
    // ACCESS without SETUP while idle
    i_apb_s_psel    = 1'b1;
    i_apb_s_penable = 1'b1;
    i_apb_s_req     = rnd_req();
    @(negedge clk);
    next_cycle();
    drive_idle();
    exp_err = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({o_protocol_err, o_req_vld, o_busy, o_apb_s_pready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL idle_violation: {err,req_vld,busy,pready} got %b want 1000",
               {o_protocol_err, o_req_vld, o_busy, o_apb_s_pready});
    end
    next_cycle();
    // psel dropped mid-transfer: still completes with one pready
    xfer(rnd_req(), rnd_resp(), 1, 2, 1'b1);
    xfer(rnd_req(), rnd_resp(), 0, 0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (o_protocol_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b want 1", o_protocol_err);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_transfer();
    i_apb_s_psel    = 1'b1;
    i_apb_s_penable = 1'b0;
    i_apb_s_req     = rnd_req();
    next_cycle();
    i_apb_s_penable = 1'b1;
    i_req_rdy       = 1'b1;
    next_cycle();
    i_req_rdy  = 1'b0;
    i_resp_vld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_resp_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_wait: resp_rdy got %b want 1", o_resp_rdy);
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive_idle();
    exp_count = 32'd0;
    exp_err   = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_req_vld, o_resp_rdy, o_apb_s_pready, o_busy, o_protocol_err} !== 5'b0 ||
        o_req_data !== tb_req_t'(0) || o_apb_s_resp !== tb_resp_t'(0) ||
        o_txn_count !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_reset_values: vld=%b rdy=%b pready=%b busy=%b err=%b req=%h resp=%h cnt=%h want all 0",
               o_req_vld, o_resp_rdy, o_apb_s_pready, o_busy, o_protocol_err,
               o_req_data, o_apb_s_resp, o_txn_count);
    end
    next_cycle();
    xfer(rnd_req(), rnd_resp(), 1, 1, 1'b0);
  endtask

  task automatic test_counter_wrap();
    force dut.txn_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.txn_count_q;
    next_cycle();
    exp_count = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++;
    if (o_txn_count !== exp_count) begin
      n_bad++;
      $display("FAIL count_preload: got %h want %h", o_txn_count, exp_count);
    end
    next_cycle();
    xfer(rnd_req(), rnd_resp(), 0, 0, 1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    i_apb_s_psel    = 1'b0;
    i_apb_s_penable = 1'b0;
    i_req_rdy       = 1'b0;
    i_resp_vld      = 1'b0;
    i_apb_s_req     = tb_req_t'(0);
    i_resp_data     = tb_resp_t'(0);
    exp_count       = 32'd0;
    exp_err         = 1'b0;

    test_reset();
    test_single_write();
    test_backpressure();
    test_back_to_back();
    test_random_waits();
    test_protocol_errors();
    test_reset_mid_transfer();
    test_counter_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
